// File: rtl/adder_col_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_col_drain_if
// Description : Snapshot-capture inputs and single-row output stream of the
//               adder column drain reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_col_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 4
);
    localparam int IDX_W = $clog2(NUM_ROWS);

    logic                           capture;
    logic [NUM_ROWS*DATA_WIDTH-1:0] result_in;
    logic [NUM_ROWS-1:0]            visible_in;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [IDX_W-1:0]               out_row_idx;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic                           busy;
    logic                           capture_drop;

    // Producer of snapshots and consumer of the row stream.
    modport master (
        output capture, result_in, visible_in, out_ready,
        input  out_data, out_row_idx, out_valid, out_last, busy, capture_drop
    );

    // The drain reader itself.
    modport slave (
        input  capture, result_in, visible_in, out_ready,
        output out_data, out_row_idx, out_valid, out_last, busy, capture_drop
    );
endinterface
`default_nettype wire

// File: rtl/adder_col_drain.sv
`default_nettype none
// ============================================================================
// Module      : adder_col_drain
// Description : Snapshots the adder column's packed result bus on a capture
//               pulse and serialises the visible rows, lowest index first,
//               onto a single-row valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_col_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 4
) (
    input  wire               clk,
    input  wire               rst,
    adder_col_drain_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_ROWS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [NUM_ROWS-1:0] C_ONE = {{(NUM_ROWS-1){1'b0}}, 1'b1};

    logic [0:0]                     r_state;
    logic [NUM_ROWS*DATA_WIDTH-1:0] r_snap;
    logic [NUM_ROWS-1:0]            r_pending;
    logic                           r_drop;

    logic [0:0]                     w_state_nxt;
    logic [NUM_ROWS*DATA_WIDTH-1:0] w_snap_nxt;
    logic [NUM_ROWS-1:0]            w_pending_nxt;
    logic                           w_drop_nxt;

    logic [IDX_W-1:0]               w_cur_idx;
    logic                           w_cur_last;
    logic                           w_xfer;
    logic                           w_cap_ok;

    // Current row is the lowest set pending bit; last when only one bit is left.
    always_comb begin
        w_cur_idx = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (r_pending[r]) begin
                w_cur_idx = IDX_W'(r);
            end
        end
        w_cur_last = (r_pending != '0) && ((r_pending & (r_pending - C_ONE)) == '0);
    end

    assign w_xfer   = (r_state == ST_DRAIN) && bus.out_ready;
    assign w_cap_ok = bus.capture && (bus.visible_in != '0);

    // State, snapshot, pending mask and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_pending <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_snap    <= w_snap_nxt;
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    // Next-state: load a snapshot when idle or on the last-beat transfer,
    // otherwise retire one row per transfer and flag discarded captures.
    always_comb begin
        w_state_nxt   = r_state;
        w_snap_nxt    = r_snap;
        w_pending_nxt = r_pending;
        w_drop_nxt    = r_drop;
        case (r_state)
            ST_IDLE: begin
                if (w_cap_ok) begin
                    w_snap_nxt    = bus.result_in;
                    w_pending_nxt = bus.visible_in;
                    w_state_nxt   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_xfer && w_cur_last) begin
                    if (w_cap_ok) begin
                        w_snap_nxt    = bus.result_in;
                        w_pending_nxt = bus.visible_in;
                    end else begin
                        w_pending_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_pending_nxt = r_pending & ~(C_ONE << w_cur_idx);
                    end
                    if (bus.capture) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // Outputs decode registered state only; idle forces the stream to zero.
    always_comb begin
        bus.out_valid    = 1'b0;
        bus.busy         = 1'b0;
        bus.out_data     = '0;
        bus.out_row_idx  = '0;
        bus.out_last     = 1'b0;
        bus.capture_drop = r_drop;
        if (r_state == ST_DRAIN) begin
            bus.out_valid   = 1'b1;
            bus.busy        = 1'b1;
            bus.out_data    = r_snap[int'(w_cur_idx) * DATA_WIDTH +: DATA_WIDTH];
            bus.out_row_idx = w_cur_idx;
            bus.out_last    = w_cur_last;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adder_col_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_col_drain
// Description : Directed and randomized bench for adder_col_drain, checked
//               against a queue-of-expected-beats reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_col_drain;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_ROWS   = 4;

    logic clk;
    logic rst;

    adder_col_drain_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_ROWS(NUM_ROWS)) ifc ();

    adder_col_drain #(.DATA_WIDTH(DATA_WIDTH), .NUM_ROWS(NUM_ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } beat_t;

    beat_t q[$];
    logic  m_drop;
    int    n_chk;
    int    n_fail;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, compare outputs produced
    // by the previous rising edge, then advance the reference model.
    task automatic cyc(input logic c, input logic [31:0] res, input logic [3:0] vis,
                       input logic rdy, input logic r);
        int hi;
        @(negedge clk);
        ifc.capture    = c;
        ifc.result_in  = res;
        ifc.visible_in = vis;
        ifc.out_ready  = rdy;
        rst            = r;

        check("valid", ifc.out_valid, q.size() > 0);
        check("busy", ifc.busy, q.size() > 0);
        check("drop", ifc.capture_drop, m_drop);
        if (q.size() > 0) begin
            check("data", ifc.out_data, q[0].d);
            check("idx", ifc.out_row_idx, q[0].i);
            check("last", ifc.out_last, q[0].l);
        end

        if (r) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (c) begin
                if (q.size() == 0) begin
                    if (vis != 0) begin
                        hi = 0;
                        for (int k = 0; k < NUM_ROWS; k++) if (vis[k]) hi = k;
                        for (int k = 0; k < NUM_ROWS; k++) begin
                            if (vis[k]) q.push_back('{d: res[k*8 +: 8], i: 2'(k), l: (k == hi)});
                        end
                    end
                end else begin
                    m_drop = 1'b1;
                end
            end
        end
    endtask

    task automatic check_zero();
        @(negedge clk);
        check("z_data", ifc.out_data, 0);
        check("z_idx", ifc.out_row_idx, 0);
        check("z_last", ifc.out_last, 0);
        check("z_valid", ifc.out_valid, 0);
        check("z_busy", ifc.busy, 0);
        check("z_drop", ifc.capture_drop, 0);
    endtask

    localparam logic [31:0] RES_A = {8'd125, 8'd230, 8'd25, 8'd30};
    localparam logic [31:0] RES_B = {8'd11, 8'd22, 8'd33, 8'd44};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_drop = 1'b0;
        rst = 1'b1;
        ifc.capture = 1'b0;
        ifc.result_in = '0;
        ifc.visible_in = '0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero();

        // Ordered drain of rows 0,1,3.
        cyc(1, RES_A, 4'b1011, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);

        // Backpressure: three stalled cycles on row 0.
        cyc(1, RES_A, 4'b1011, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);

        // Empty mask is ignored.
        cyc(1, RES_B, 4'b0000, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Drop: second capture on the 2nd drain cycle.
        cyc(1, RES_A, 4'b1111, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, RES_B, 4'b1111, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);

        // Reset mid-drain after one beat; clears the sticky drop too.
        cyc(1, RES_B, 4'b1111, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        check_zero();
        repeat (4) cyc(0, 0, 0, 1, 0);

        // Back-to-back: new capture lands on the last-beat transfer.
        cyc(1, {8'd1, 8'd2, 8'd3, 8'd4}, 4'b0001, 1, 0);
        cyc(1, {8'd5, 8'd6, 8'd7, 8'd8}, 4'b1000, 1, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 3) == 0), $urandom, 4'($urandom_range(1, 15)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        repeat (8) cyc(0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
